// File: rtl/freq_pkg.sv
// freq_pkg: measurement window, rate limit and FSM encodings shared by the
// frequency generator and the frequency counter.
package freq_pkg;
    localparam int UPDATE_PERIOD = 12000;
    localparam int MAX_RATE = 99;
    typedef enum logic [1:0] {STATE_IDLE, STATE_DIVIDE, STATE_RUN} state_t;
endpackage

// File: rtl/rate_divider.sv
// rate_divider: iterative-subtraction divider, quotient = floor(UPDATE_PERIOD / divisor).
module rate_divider #(
    parameter int UPDATE_PERIOD = freq_pkg::UPDATE_PERIOD,
    parameter int BITS = 14
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [BITS-1:0] divisor,
    output logic [BITS-1:0] quotient,
    output logic            done
);
    logic [BITS-1:0] rem;
    logic [BITS-1:0] d;
    logic            active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem      <= '0;
            d        <= '0;
            quotient <= '0;
            active   <= 1'b0;
        end else if (start) begin
            rem      <= BITS'(UPDATE_PERIOD);
            d        <= divisor;
            quotient <= '0;
            active   <= 1'b1;
        end else if (active) begin
            if (rem >= d) begin
                rem      <= rem - d;
                quotient <= quotient + BITS'(1);
            end else begin
                active <= 1'b0;
            end
        end
    end

    // Combinational so the caller can leave DIVIDE on the same edge the loop ends.
    assign done = active && rem < d;
endmodule

// File: rtl/frequency_generator.sv
// frequency_generator: square wave with a programmable number of rising edges
// per UPDATE_PERIOD-cycle window.
module frequency_generator #(
    parameter int UPDATE_PERIOD = freq_pkg::UPDATE_PERIOD,
    parameter int BITS = 14,
    parameter int MAX_RATE = freq_pkg::MAX_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] rate,
    input  logic       rate_load,
    output logic       busy,
    output logic       signal,
    output logic       rise
);
    import freq_pkg::*;

    state_t          state, state_n;
    logic [6:0]      r;
    logic [7:0]      two_r;
    logic            load, start, done;
    logic [BITS-1:0] quotient, half, cnt;

    assign r     = rate > 7'(MAX_RATE) ? 7'(MAX_RATE) : rate;
    assign two_r = {r, 1'b0};
    assign load  = rate_load && state != STATE_DIVIDE;
    assign start = load && r != 7'd0;
    assign busy  = state == STATE_DIVIDE;

    rate_divider #(.UPDATE_PERIOD(UPDATE_PERIOD), .BITS(BITS)) u_div (
        .clk(clk),
        .reset(reset),
        .start(start),
        .divisor(BITS'(two_r)),
        .quotient(quotient),
        .done(done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= STATE_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (load)
            state_n = r == 7'd0 ? STATE_IDLE : STATE_DIVIDE;
        else if (state == STATE_DIVIDE && done)
            state_n = STATE_RUN;
    end

    // A reload wins over the toggle so the output never glitches high mid-reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            signal <= 1'b0;
            rise   <= 1'b0;
            half   <= '0;
            cnt    <= '0;
        end else begin
            rise <= 1'b0;
            if (load) begin
                signal <= 1'b0;
            end else if (state == STATE_DIVIDE && done) begin
                half   <= quotient;
                cnt    <= '0;
                signal <= 1'b1;
                rise   <= 1'b1;
            end else if (state == STATE_RUN) begin
                if (cnt == half - BITS'(1)) begin
                    signal <= ~signal;
                    rise   <= ~signal;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + BITS'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_frequency_generator.sv
// tb_frequency_generator: table of rate loads with a queue of expected timings,
// plus hand-written sequences for zero rate, ignored loads, reloads and async reset.
module tb_frequency_generator;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rate_load = 1'b0;
    logic [6:0] rate = 7'd0;
    logic       busy, signal, rise;
    int         n_pass = 0;
    int         n_total = 0;

    typedef struct { int rate; int busy_len; int half; int rises; } vec_t;
    typedef struct { int busy_len; int half; int rises; } exp_t;
    exp_t sb[$];
    vec_t vecs[6];

    frequency_generator dut (
        .clk(clk),
        .reset(reset),
        .rate(rate),
        .rate_load(rate_load),
        .busy(busy),
        .signal(signal),
        .rise(rise)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int r);
        rate = 7'(r);
        rate_load = 1'b1;
        tick();
        rate_load = 1'b0;
    endtask

    task automatic expect_run(input int b, input int h, input int w);
        exp_t e;
        e.busy_len = b;
        e.half = h;
        e.rises = w;
        sb.push_back(e);
    endtask

    // Called right after the load edge; pre counts busy samples already consumed.
    task automatic measure(input string tag, input int pre);
        exp_t e;
        int n, r;
        e = sb.pop_front();
        n = pre;
        while (busy && n < 20000) begin n++; tick(); end
        check({tag, " busy_len"}, n, e.busy_len);
        check({tag, " signal_rise_at_start"}, int'({signal, rise}), 3);
        n = 0; r = 0;
        while (signal && n < 20000) begin n++; r += int'(rise); tick(); end
        check({tag, " high_len"}, n, e.half);
        check({tag, " rises_in_high"}, r, 1);
        n = 0;
        while (!signal && n < 20000) begin n++; tick(); end
        check({tag, " low_len"}, n, e.half);
        check({tag, " rise_at_toggle"}, int'(rise), 1);
        if (e.rises > 0) begin
            r = 0;
            for (int i = 0; i < 12000; i++) begin tick(); r += int'(rise); end
            check({tag, " rises_per_window"}, r, e.rises);
        end
    endtask

    initial begin
        int n, r, b;
        vecs[0] = '{rate: 10,  busy_len: 601,  half: 600,  rises: 10};
        vecs[1] = '{rate: 120, busy_len: 61,   half: 60,   rises: 100};
        vecs[2] = '{rate: 5,   busy_len: 1201, half: 1200, rises: 0};
        vecs[3] = '{rate: 20,  busy_len: 301,  half: 300,  rises: 0};
        vecs[4] = '{rate: 50,  busy_len: 121,  half: 120,  rises: 0};
        vecs[5] = '{rate: 33,  busy_len: 182,  half: 181,  rises: 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset signal", int'(signal), 0);
        check("reset rise", int'(rise), 0);
        reset = 1'b0;
        r = 0;
        for (int i = 0; i < 50; i++) begin tick(); r += int'(signal) + int'(busy); end
        check("idle_without_load activity", r, 0);

        foreach (vecs[i]) begin
            expect_run(vecs[i].busy_len, vecs[i].half, vecs[i].rises);
            load(vecs[i].rate);
            measure($sformatf("rate%0d", vecs[i].rate), 0);
        end

        // rate 0 while running: stop and stay quiet
        n = 0;
        while (!signal && n < 5000) begin n++; tick(); end
        load(0);
        check("zero_load signal", int'(signal), 0);
        check("zero_load busy", int'(busy), 0);
        r = 0; b = 0;
        for (int i = 0; i < 3000; i++) begin tick(); r += int'(rise) + int'(signal); b += int'(busy); end
        check("zero_load activity", r, 0);
        check("zero_load busy_cycles", b, 0);

        // load during DIVIDE is dropped
        expect_run(1201, 1200, 0);
        load(5);
        repeat (10) tick();
        rate = 7'd50;
        rate_load = 1'b1;
        tick();
        rate_load = 1'b0;
        measure("ignored_load", 11);

        // reload mid-high-phase
        load(10);
        n = 0;
        while (busy && n < 20000) begin n++; tick(); end
        repeat (100) tick();
        check("pre_reload signal", int'(signal), 1);
        expect_run(301, 300, 0);
        load(20);
        check("reload signal_drop", int'(signal), 0);
        measure("reload20", 0);

        // async reset mid-high-phase
        load(10);
        n = 0;
        while (busy && n < 20000) begin n++; tick(); end
        repeat (5) tick();
        #3 reset = 1'b1;
        #1;
        check("async_reset_run signal", int'(signal), 0);
        check("async_reset_run rise", int'(rise), 0);
        tick();
        reset = 1'b0;
        load(5);
        repeat (20) tick();
        #2 reset = 1'b1;
        #1;
        check("async_reset_divide busy", int'(busy), 0);
        tick();
        reset = 1'b0;
        r = 0;
        for (int i = 0; i < 2000; i++) begin tick(); r += int'(rise) + int'(signal) + int'(busy); end
        check("post_reset activity", r, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
